// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM for the multicycle MIPS-subset CPU. Steps each instruction
//   through FETCH / DECODE / EXEC / MEM / WB over a shared datapath. Memory is
//   reached through a request/ready handshake. The FSM adds j, memory wait
//   states, a sticky fault state and a counter of retired instructions.
//
// Parameters
//   TIMEOUT  maximum cycles spent waiting on mem_ready before FAULT (>= 1)
//   CNT_W    width of instr_count
//   EN_JUMP  1: j (op 000010) is decoded; 0: j is treated as illegal
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op, fun           IR[31:26] and IR[5:0]; op is valid from DECODE onward
//   zero, sign        ALU zero flag and ALU result bit 31
//   mem_ready         memory finishes the current request this cycle
//   mem_req, mem_we   memory request; mem_we marks a write (sw only)
//   IorD              memory address select (0 PC, 1 ALUOut)
//   IRWrite, PCWrite  IR / PC load enables
//   PCSource          0 ALU result, 1 ALUOut, 2 jump target
//   ALUSrcA, ALUSrcB  ALU operand selects
//   ALUctr            ALU operation
//   ExtOp, RegDst     sign-extend imm16; destination register is Rd
//   RegWr, MemToReg   register write; write data comes from MDR
//   fault             set in the FAULT state; only rst_n clears it
//   instr_count       retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32,
  parameter bit          EN_JUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       fun,
  input  logic             zero,
  input  logic             sign,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUctr,
  output logic             ExtOp,
  output logic             RegDst,
  output logic             RegWr,
  output logic             MemToReg,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  // wait_cnt never has to hold more than TIMEOUT-1: the wait cycle that
  // would reach TIMEOUT goes to FAULT instead.
  localparam int unsigned     WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_FAULT
  } state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  instr_count_reg;
  logic              retire;
  logic              wait_last;
  logic              fun_legal;
  logic [2:0]        r_alu;

  assign wait_last   = (wait_cnt_reg == WAIT_LAST);
  assign instr_count = instr_count_reg;

  // R-type function decode. sub and subu share the same ALU operation.
  always_comb begin
    fun_legal = 1'b1;
    r_alu     = 3'd0;
    case (fun)
      6'b100000: r_alu = 3'd2;  // add
      6'b100001: r_alu = 3'd4;  // addu
      6'b100010: r_alu = 3'd6;  // sub
      6'b100011: r_alu = 3'd6;  // subu
      6'b100100: r_alu = 3'd0;  // and
      6'b100101: r_alu = 3'd1;  // or
      6'b000000: r_alu = 3'd5;  // sll
      6'b101010: r_alu = 3'd3;  // slt
      6'b101011: r_alu = 3'd7;  // sltu
      default:   fun_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= '0;
      instr_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (retire) begin
        instr_count_reg <= instr_count_reg + CNT_W'(1);
      end
    end
  end

  // Next state and control outputs. wait_cnt defaults to zero, so it is
  // cleared on every cycle that is not a stalled memory cycle; that covers
  // entry into each memory state.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCSource      = 2'd0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'd0;
    ALUctr        = 3'd0;
    ExtOp         = 1'b0;
    RegDst        = 1'b0;
    RegWr         = 1'b0;
    MemToReg      = 1'b0;
    fault         = 1'b0;

    case (state_reg)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        // PC <= PC + 4 is computed by the ALU while the instruction is read.
        mem_req = 1'b1;
        ALUSrcB = 2'd1;
        ALUctr  = 3'd4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)      state_next = S_DECODE;
        else if (wait_last) state_next = S_FAULT;
        else                wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end

      S_DECODE: begin
        // Branch target (PC + Imm32<<2) lands in ALUOut for a later BRANCH.
        ALUSrcB = 2'd3;
        ALUctr  = 3'd4;
        ExtOp   = 1'b1;
        case (op)
          OP_RTYPE:                state_next = fun_legal ? S_EXEC_R : S_FAULT;
          OP_ADDI:                 state_next = S_EXEC_I;
          OP_LW, OP_SW:            state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BGTZ: state_next = S_BRANCH;
          OP_J:                    state_next = EN_JUMP ? S_JUMP : S_FAULT;
          default:                 state_next = S_FAULT;
        endcase
      end

      S_EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUctr     = r_alu;
        state_next = S_WB_R;
      end

      S_WB_R: begin
        RegDst     = 1'b1;
        RegWr      = 1'b1;
        ALUctr     = r_alu;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ExtOp      = 1'b1;
        ALUctr     = 3'd2;
        state_next = S_WB_I;
      end

      S_WB_I: begin
        RegWr      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ExtOp      = 1'b1;
        ALUctr     = 3'd4;
        state_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)      state_next = S_WB_MEM;
        else if (wait_last) state_next = S_FAULT;
        else                wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
      end

      S_WB_MEM: begin
        RegWr      = 1'b1;
        MemToReg   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (wait_last) begin
          state_next = S_FAULT;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end

      S_BRANCH: begin
        // ALU computes busA - busB only to produce zero/sign for the test.
        ALUSrcA    = 1'b1;
        ALUctr     = 3'd6;
        PCSource   = 2'd1;
        PCWrite    = ((op == OP_BEQ)  &&  zero) ||
                     ((op == OP_BNE)  && !zero) ||
                     ((op == OP_BGTZ) && !zero && !sign);
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        PCSource   = 2'd2;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_FAULT: fault = 1'b1;

      default: state_next = S_FAULT;
    endcase
  end

endmodule
